guess_sched: RTL and testbench
==============================

Name: guess_sched

Overview:
- Multi-player guess scheduler in front of the hangman game-logic core.
- Arbitrates letter requests from NPLAYERS wireless receiver channels using round-robin.
- Rejects invalid and already-used letters, then issues each accepted letter to the core as a single-cycle non-zero guess.
- Tracks the core's busy/ready handshake, attributes each hit or miss to the issuing player, and keeps per-player scores.

Parameters:
- NPLAYERS, 2: number of requester channels (2..4).
- BUSY_TIMEOUT, 15: maximum cycles to wait for core red_busy after issuing a guess.

Ports:
- clk  in  1  clock
- nRst  in  1  reset, asynchronous, active-low
- req_valid  in  NPLAYERS  per-player request pending; level; held until req_ack
- req_letter  in  8*NPLAYERS  ASCII letter, player p at [8p+7:8p]
- req_ack  out  NPLAYERS  one-cycle pulse: request consumed (accepted or rejected)
- game_rdy  in  1  core ready for a guess
- red_busy  in  1  core evaluating a guess
- mistake  in  1  core single-cycle miss flag (valid on cycle red_busy falls)
- correct  in  3  core correct-letter count
- incorrect  in  3  core mistake count
- gameEnd  in  1  new-game request
- guess  out  8  to core; non-zero for exactly one cycle per issue, else 0
- cur_player  out  2  player owning the in-flight guess
- dup_reject  out  1  one-cycle pulse: letter already used or non-alphabetic
- hit  out  1  one-cycle pulse: in-flight guess was correct
- miss  out  1  one-cycle pulse: in-flight guess was wrong
- timeout_err  out  1  one-cycle pulse: core did not go busy
- game_over  out  1  level: correct==5 or incorrect==6
- score  out  4*NPLAYERS  per-player hit counters, saturating at 15

Behaviour:
- Reset values: all outputs 0; internal used-letter bitmap cleared; round-robin pointer 0; state ARB.
- Letter normalisation:
  - 'a'..'z' (0x61-0x7A) folds to uppercase before checks and issue.
  - 'A'..'Z' (0x41-0x5A) passes unchanged.
  - Any other code is invalid.
  - Bitmap index is letter-0x41.
- game_over is combinational from the correct/incorrect inputs.
- States:
  - ARB:
    - If gameEnd: go to CLEAR.
    - Else if game_over: stay; no req_ack.
    - Else if game_rdy and any req_valid:
      - Select the first valid player at or after the pointer, wrapping.
      - Pulse req_ack for that player; the pointer becomes winner+1 mod NPLAYERS.
      - If the letter is invalid or its bitmap bit is set: pulse dup_reject, stay in ARB.
      - Else: set the bitmap bit, latch cur_player, go to ISSUE.
  - ISSUE: drive guess = normalised letter for this one cycle; timer=0; go to WAIT_BUSY.
  - WAIT_BUSY:
    - red_busy=1: go to WAIT_DONE.
    - Else timer++; timer==BUSY_TIMEOUT: pulse timeout_err, clear that letter's bitmap bit, go to ARB.
  - WAIT_DONE: on the first cycle with red_busy=0 and game_rdy=1:
    - mistake=1: pulse miss.
    - Else: pulse hit, score[cur_player]++ (saturating).
    - Go to ARB; the next arbitration can occur no earlier than the following cycle.
  - CLEAR: clear bitmap, scores, and pointer; guess=0; go to ARB.
- gameEnd mid-guess (ISSUE/WAIT_*): takes priority; go to CLEAR next cycle; no hit/miss/timeout pulse for the aborted guess.
- Simultaneous requests: only one req_ack per cycle. Losers keep req_valid and win on later rounds by rotation.
- req_valid dropping before ack: no effect, nothing latched.
- guess is registered, never non-zero outside ISSUE. hit/miss/dup_reject/timeout_err are mutually exclusive per cycle.
- Minimum accepted-guess latency: req_ack at cycle 0, guess at cycle 1.

Test Plan:
1. Reset, then P0 requests 'h' with game_rdy=1 -> req_ack[0] at T, guess=0x48 for exactly one cycle at T+1, cur_player=0.
2. Core raises red_busy at T+2 for 5 cycles, then red_busy=0, game_rdy=1, mistake=0 -> hit pulse, score[0]=1; with mistake=1 -> miss pulse, score unchanged.
3. P0 and P1 both valid with pointer=0 -> P0 acked first; after completion P1 acked; then P0 again (rotation).
4. P1 requests 'H' after 'h' was used, and a separate request of 0x31 -> each gets req_ack and dup_reject, guess stays 0, state stays ARB.
5. red_busy never rises -> timeout_err 15 cycles after entering WAIT_BUSY; the letter can be re-guessed afterwards.
6. correct=5 while requests are pending -> game_over=1, no req_ack. gameEnd asserted during WAIT_DONE -> scores=0, bitmap cleared, previously used letter accepted again.

Source files
------------

// File: rtl/guess_sched.sv
// guess_sched: multi-player guess scheduler in front of the hangman core.
// Round-robin arbitrates letter requests, rejects invalid or reused letters,
// issues accepted letters to the core as single-cycle guesses, then tracks
// the core's busy/ready handshake to credit hits per player.
//
// Ports:
//   clk, nRst            clock, async active-low reset
//   req_valid/req_letter per-player request level and ASCII letter
//   req_ack              one-cycle pulse when a request is consumed
//   game_rdy, red_busy   core handshake
//   mistake              core miss flag, valid the cycle red_busy falls
//   correct, incorrect   core letter/mistake counts (drive game_over)
//   gameEnd              new-game request, clears letters/scores/pointer
//   guess                letter to the core, non-zero for one cycle per issue
//   cur_player           player owning the in-flight guess
//   dup_reject/hit/miss/timeout_err  mutually exclusive one-cycle pulses
//   game_over            combinational: correct==5 or incorrect==6
//   score                per-player saturating hit counters, 4 bits each
module guess_sched #(
  parameter int unsigned NPLAYERS     = 2,
  parameter int unsigned BUSY_TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    nRst,
  input  logic [NPLAYERS-1:0]     req_valid,
  input  logic [8*NPLAYERS-1:0]   req_letter,
  output logic [NPLAYERS-1:0]     req_ack,
  input  logic                    game_rdy,
  input  logic                    red_busy,
  input  logic                    mistake,
  input  logic [2:0]              correct,
  input  logic [2:0]              incorrect,
  input  logic                    gameEnd,
  output logic [7:0]              guess,
  output logic [1:0]              cur_player,
  output logic                    dup_reject,
  output logic                    hit,
  output logic                    miss,
  output logic                    timeout_err,
  output logic                    game_over,
  output logic [4*NPLAYERS-1:0]   score
);

  localparam int unsigned NLETTERS = 26;
  localparam int unsigned TW       = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [2:0] {
    ARB       = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    CLEAR     = 3'd4
  } state_t;

  state_t              state;
  logic [1:0]          ptr;
  logic [NLETTERS-1:0] used;
  logic [TW-1:0]       timer;
  logic [7:0]          cur_letter;
  logic [4:0]          cur_idx;

  logic [NPLAYERS-1:0] elig;
  logic                win_found;
  logic [1:0]          win_idx;
  logic [NPLAYERS-1:0] win_onehot;
  logic [1:0]          ptr_next;
  logic [7:0]          raw_letter;
  logic [7:0]          norm_letter;
  logic                norm_valid;
  logic [4:0]          norm_idx;
  logic                letter_used;
  logic [TW-1:0]       timer_inc;
  logic [3:0]          cur_score;

  assign game_over = (correct == 3'd5) || (incorrect == 3'd6);

  // A player acked last cycle is masked so its still-high request level is not
  // consumed twice before the requester has seen the ack.
  assign elig = req_valid & ~req_ack;

  // Round-robin: first eligible player at or after the pointer, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    for (int unsigned i = 0; i < NPLAYERS; i++) begin
      int unsigned k;
      k = (32'(ptr) + i) % NPLAYERS;
      if (!win_found && 1'(elig >> k)) begin
        win_found = 1'b1;
        win_idx   = 2'(k);
      end
    end
  end

  assign win_onehot = {{(NPLAYERS-1){1'b0}}, 1'b1} << win_idx;
  assign ptr_next   = 2'((32'(win_idx) + 32'd1) % NPLAYERS);
  assign raw_letter = 8'(req_letter >> (8 * win_idx));

  // Fold lowercase to uppercase; anything outside A-Z/a-z is invalid.
  always_comb begin
    norm_letter = raw_letter;
    norm_valid  = 1'b0;
    if (raw_letter >= 8'h61 && raw_letter <= 8'h7A) begin
      norm_letter = raw_letter - 8'h20;
      norm_valid  = 1'b1;
    end else if (raw_letter >= 8'h41 && raw_letter <= 8'h5A) begin
      norm_valid  = 1'b1;
    end
  end

  assign norm_idx    = 5'(norm_letter - 8'h41);
  assign letter_used = 1'(used >> norm_idx);
  assign timer_inc   = timer + TW'(1);
  assign cur_score   = 4'(score >> (4 * cur_player));

  // Scheduler state machine with registered outputs.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state       <= ARB;
      ptr         <= 2'd0;
      used        <= '0;
      timer       <= '0;
      cur_letter  <= 8'd0;
      cur_idx     <= 5'd0;
      req_ack     <= '0;
      guess       <= 8'd0;
      cur_player  <= 2'd0;
      dup_reject  <= 1'b0;
      hit         <= 1'b0;
      miss        <= 1'b0;
      timeout_err <= 1'b0;
      score       <= '0;
    end else begin
      req_ack     <= '0;
      guess       <= 8'd0;
      dup_reject  <= 1'b0;
      hit         <= 1'b0;
      miss        <= 1'b0;
      timeout_err <= 1'b0;

      case (state)
        ARB: begin
          if (gameEnd) begin
            state <= CLEAR;
          end else if (!game_over && game_rdy && win_found) begin
            req_ack <= win_onehot;
            ptr     <= ptr_next;
            if (!norm_valid || letter_used) begin
              dup_reject <= 1'b1;
            end else begin
              used[norm_idx] <= 1'b1;
              cur_player     <= win_idx;
              cur_letter     <= norm_letter;
              cur_idx        <= norm_idx;
              state          <= ISSUE;
            end
          end
        end

        ISSUE: begin
          if (gameEnd) begin
            state <= CLEAR;
          end else begin
            guess <= cur_letter;
            timer <= '0;
            state <= WAIT_BUSY;
          end
        end

        WAIT_BUSY: begin
          if (gameEnd) begin
            state <= CLEAR;
          end else if (red_busy) begin
            state <= WAIT_DONE;
          end else if (timer_inc == TW'(BUSY_TIMEOUT)) begin
            // Core never took the guess: release the letter for a retry.
            timeout_err   <= 1'b1;
            used[cur_idx] <= 1'b0;
            state         <= ARB;
          end else begin
            timer <= timer_inc;
          end
        end

        WAIT_DONE: begin
          if (gameEnd) begin
            state <= CLEAR;
          end else if (!red_busy && game_rdy) begin
            if (mistake) begin
              miss <= 1'b1;
            end else begin
              hit <= 1'b1;
              if (cur_score != 4'hF)
                score[4*cur_player +: 4] <= cur_score + 4'd1;
            end
            state <= ARB;
          end
        end

        CLEAR: begin
          used  <= '0;
          score <= '0;
          ptr   <= 2'd0;
          state <= ARB;
        end

        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_guess_sched.sv
// tb_guess_sched: directed self-checking bench for guess_sched (2 players).
module tb_guess_sched;

  logic        clk;
  logic        nRst;
  logic [1:0]  req_valid;
  logic [15:0] req_letter;
  logic [1:0]  req_ack;
  logic        game_rdy;
  logic        red_busy;
  logic        mistake;
  logic [2:0]  correct;
  logic [2:0]  incorrect;
  logic        gameEnd;
  logic [7:0]  guess;
  logic [1:0]  cur_player;
  logic        dup_reject;
  logic        hit;
  logic        miss;
  logic        timeout_err;
  logic        game_over;
  logic [7:0]  score;

  int errors = 0;
  int checks = 0;

  guess_sched #(.NPLAYERS(2), .BUSY_TIMEOUT(15)) dut (
    .clk         (clk),
    .nRst        (nRst),
    .req_valid   (req_valid),
    .req_letter  (req_letter),
    .req_ack     (req_ack),
    .game_rdy    (game_rdy),
    .red_busy    (red_busy),
    .mistake     (mistake),
    .correct     (correct),
    .incorrect   (incorrect),
    .gameEnd     (gameEnd),
    .guess       (guess),
    .cur_player  (cur_player),
    .dup_reject  (dup_reject),
    .hit         (hit),
    .miss        (miss),
    .timeout_err (timeout_err),
    .game_over   (game_over),
    .score       (score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input int p, input logic [7:0] l);
    req_letter[8*p +: 8] = l;
    req_valid[p] = 1'b1;
  endtask

  // Called right after the ack cycle of an accepted request: checks the issue
  // cycle, holds the core busy for 5 cycles, then completes with hit or miss.
  task automatic finish_guess(input string tag, input logic [7:0] eg,
                              input logic [1:0] ep, input bit mis);
    tick();
    check({tag, "_guess"}, guess, eg);
    check({tag, "_player"}, cur_player, ep);
    red_busy = 1'b1;
    tick();
    check({tag, "_guess_one_cycle"}, guess, 8'h00);
    repeat (4) tick();
    red_busy = 1'b0;
    mistake  = mis;
    tick();
    check({tag, "_hit"}, hit, !mis);
    check({tag, "_miss"}, miss, mis);
    mistake = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    nRst = 1'b0; req_valid = 2'b00; req_letter = 16'h0000;
    game_rdy = 1'b0; red_busy = 1'b0; mistake = 1'b0;
    correct = 3'd0; incorrect = 3'd0; gameEnd = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_guess", guess, 8'h00);
    check("rst_ack", req_ack, 2'b00);
    check("rst_score", score, 8'h00);
    check("rst_pulses", {dup_reject, hit, miss, timeout_err}, 4'b0000);
    nRst = 1'b1;
    game_rdy = 1'b1;
    tick();

    // 1/2: P0 'h' -> 'H' issued, hit, score0=1
    set_req(0, 8'h68);
    tick();
    check("t1_ack", req_ack, 2'b01);
    check("t1_guess_before", guess, 8'h00);
    req_valid[0] = 1'b0;
    finish_guess("t1", 8'h48, 2'd0, 1'b0);
    check("t1_score", score, 8'h01);
    tick();
    check("t1_hit_pulse_end", hit, 1'b0);

    // P1 'b' -> miss, scores unchanged; pointer returns to 0
    set_req(1, 8'h62);
    tick();
    check("t2_ack", req_ack, 2'b10);
    req_valid[1] = 1'b0;
    finish_guess("t2", 8'h42, 2'd1, 1'b1);
    check("t2_score", score, 8'h01);

    // 3: both valid with pointer 0 -> P0, then P1, then P0 again
    set_req(0, 8'h63);
    set_req(1, 8'h44);
    tick();
    check("t3_ack_p0", req_ack, 2'b01);
    req_valid[0] = 1'b0;
    finish_guess("t3a", 8'h43, 2'd0, 1'b0);
    check("t3a_score", score, 8'h02);
    tick();
    check("t3_ack_p1", req_ack, 2'b10);
    req_valid[1] = 1'b0;
    finish_guess("t3b", 8'h44, 2'd1, 1'b0);
    check("t3b_score", score, 8'h12);
    set_req(0, 8'h65);
    set_req(1, 8'h66);
    tick();
    check("t3_ack_p0_again", req_ack, 2'b01);
    req_valid[0] = 1'b0;
    finish_guess("t3c", 8'h45, 2'd0, 1'b1);
    tick();
    check("t3_ack_p1_again", req_ack, 2'b10);
    req_valid[1] = 1'b0;
    finish_guess("t3d", 8'h46, 2'd1, 1'b0);
    check("t3d_score", score, 8'h22);

    // 4: reused 'H' and non-letter '1' are rejected
    set_req(1, 8'h48);
    tick();
    check("t4_dup_ack", req_ack, 2'b10);
    check("t4_dup_reject", dup_reject, 1'b1);
    check("t4_dup_guess", guess, 8'h00);
    req_valid[1] = 1'b0;
    tick();
    check("t4_dup_pulse_end", dup_reject, 1'b0);
    check("t4_dup_no_issue", guess, 8'h00);
    set_req(1, 8'h31);
    tick();
    check("t4_inv_ack", req_ack, 2'b10);
    check("t4_inv_reject", dup_reject, 1'b1);
    req_valid[1] = 1'b0;
    tick();
    check("t4_inv_no_issue", guess, 8'h00);

    // 5: core never busy -> timeout after 15 WAIT_BUSY cycles; letter reusable
    set_req(0, 8'h7A);
    tick();
    check("t5_ack", req_ack, 2'b01);
    req_valid[0] = 1'b0;
    tick();
    check("t5_guess", guess, 8'h5A);
    repeat (14) tick();
    check("t5_no_timeout_yet", timeout_err, 1'b0);
    tick();
    check("t5_timeout", timeout_err, 1'b1);
    check("t5_no_hit_miss", {hit, miss}, 2'b00);
    tick();
    check("t5_timeout_end", timeout_err, 1'b0);
    set_req(1, 8'h5A);
    tick();
    check("t5_retry_ack", req_ack, 2'b10);
    check("t5_retry_no_reject", dup_reject, 1'b0);
    req_valid[1] = 1'b0;
    finish_guess("t5r", 8'h5A, 2'd1, 1'b0);
    check("t5_score", score, 8'h32);

    // 6: game over blocks arbitration
    incorrect = 3'd6;
    #1 check("t6_over_incorrect", game_over, 1'b1);
    incorrect = 3'd0;
    correct = 3'd5;
    #1 check("t6_over_correct", game_over, 1'b1);
    set_req(0, 8'h6B);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_no_ack", req_ack, 2'b00);
    end
    correct = 3'd0;
    #1 check("t6_not_over", game_over, 1'b0);
    tick();
    check("t6_ack", req_ack, 2'b01);
    req_valid[0] = 1'b0;
    tick();
    check("t6_guess", guess, 8'h4B);
    red_busy = 1'b1;
    tick();
    gameEnd = 1'b1;
    tick();
    check("t6_abort_no_pulse", {hit, miss, timeout_err}, 3'b000);
    gameEnd  = 1'b0;
    red_busy = 1'b0;
    tick();
    check("t6_score_cleared", score, 8'h00);
    check("t6_clear_no_pulse", {hit, miss}, 2'b00);
    set_req(0, 8'h68);
    tick();
    check("t6_reuse_ack", req_ack, 2'b01);
    check("t6_reuse_no_reject", dup_reject, 1'b0);
    req_valid[0] = 1'b0;
    finish_guess("t6r", 8'h48, 2'd0, 1'b0);
    check("t6_score_after", score, 8'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
